// File: rtl/conveyor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conveyor_pkg -- shared widths, fault codes and conveyor record types   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package conveyor_pkg;

  localparam int DEFAULT_WORD_WIDTH          = 32;
  localparam int DEFAULT_CONVEYOR_ADDR_WIDTH = 4;
  localparam int DEFAULT_FAULT_ADDR_WIDTH    = 3;
  localparam int DEFAULT_FIFO_ADDR_WIDTH     = 2;

  localparam int CONVEYOR_WIDTH = 1 + DEFAULT_FAULT_ADDR_WIDTH + DEFAULT_WORD_WIDTH;

  localparam logic [DEFAULT_FAULT_ADDR_WIDTH-1:0] F_NONE     = 3'b000;
  localparam logic [DEFAULT_FAULT_ADDR_WIDTH-1:0] F_ILLEGAL  = 3'b001;
  localparam logic [DEFAULT_FAULT_ADDR_WIDTH-1:0] F_MEM      = 3'b010;
  localparam logic [DEFAULT_FAULT_ADDR_WIDTH-1:0] F_MISALIGN = 3'b011;
  localparam logic [DEFAULT_FAULT_ADDR_WIDTH-1:0] F_DIVZERO  = 3'b100;

  typedef struct packed {
    logic                                   ctx;
    logic [DEFAULT_CONVEYOR_ADDR_WIDTH-1:0] slot;
    logic [DEFAULT_FAULT_ADDR_WIDTH-1:0]    fault;
    logic [DEFAULT_WORD_WIDTH-1:0]          value;
  } retire_entry_t;

  typedef struct packed {
    logic                                finished;
    logic [DEFAULT_FAULT_ADDR_WIDTH-1:0] fault;
    logic [DEFAULT_WORD_WIDTH-1:0]       value;
  } conveyor_slot_t;

endpackage
`default_nettype wire

// File: rtl/conveyor_retire_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conveyor_retire_if -- producer ports and conveyor write port           |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface conveyor_retire_if #(
  parameter int WORD_WIDTH          = conveyor_pkg::DEFAULT_WORD_WIDTH,
  parameter int CONVEYOR_ADDR_WIDTH = conveyor_pkg::DEFAULT_CONVEYOR_ADDR_WIDTH,
  parameter int FAULT_ADDR_WIDTH    = conveyor_pkg::DEFAULT_FAULT_ADDR_WIDTH,
  parameter int FIFO_ADDR_WIDTH     = conveyor_pkg::DEFAULT_FIFO_ADDR_WIDTH
);
  logic                           p0_valid;
  logic                           p0_ready;
  logic                           p0_ctx;
  logic [CONVEYOR_ADDR_WIDTH-1:0] p0_slot;
  logic [FAULT_ADDR_WIDTH-1:0]    p0_fault;
  logic [WORD_WIDTH-1:0]          p0_value;

  logic                           p1_valid;
  logic                           p1_ready;
  logic                           p1_ctx;
  logic [CONVEYOR_ADDR_WIDTH-1:0] p1_slot;
  logic [FAULT_ADDR_WIDTH-1:0]    p1_fault;
  logic [WORD_WIDTH-1:0]          p1_value;

  logic                                  cv_we;
  logic                                  cv_ready;
  logic                                  cv_ctx;
  logic [CONVEYOR_ADDR_WIDTH-1:0]        cv_slot;
  logic [FAULT_ADDR_WIDTH+WORD_WIDTH:0]  cv_entry;
  logic [FIFO_ADDR_WIDTH:0]              pending;
  logic                                  idle;

  modport master (
    output p0_valid, p0_ctx, p0_slot, p0_fault, p0_value,
    input  p0_ready,
    output p1_valid, p1_ctx, p1_slot, p1_fault, p1_value,
    input  p1_ready,
    output cv_ready,
    input  cv_we, cv_ctx, cv_slot, cv_entry, pending, idle
  );

  modport slave (
    input  p0_valid, p0_ctx, p0_slot, p0_fault, p0_value,
    output p0_ready,
    input  p1_valid, p1_ctx, p1_slot, p1_fault, p1_value,
    output p1_ready,
    input  cv_ready,
    output cv_we, cv_ctx, cv_slot, cv_entry, pending, idle
  );

endinterface
`default_nettype wire

// File: rtl/conveyor_retire_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | retire_fifo -- synchronous FIFO with occupancy count, async reset      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module retire_fifo #(
  parameter int ADDR_WIDTH = 2,
  parameter int WIDTH      = 40
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage needs no reset: nothing reads it while the count says empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/conveyor_retire.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conveyor_retire -- arbitrates two result ports into in-order retires   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module conveyor_retire
  import conveyor_pkg::*;
#(
  parameter int WORD_WIDTH          = DEFAULT_WORD_WIDTH,
  parameter int CONVEYOR_ADDR_WIDTH = DEFAULT_CONVEYOR_ADDR_WIDTH,
  parameter int FAULT_ADDR_WIDTH    = DEFAULT_FAULT_ADDR_WIDTH,
  parameter int FIFO_ADDR_WIDTH     = DEFAULT_FIFO_ADDR_WIDTH
) (
  input  logic           clk,
  input  logic           reset_n,
  conveyor_retire_if.slave bus
);
  localparam int ENTRY_W = 1 + CONVEYOR_ADDR_WIDTH + FAULT_ADDR_WIDTH + WORD_WIDTH;

  logic                           last_grant_q;
  logic                           last_grant_d;
  logic                           grant0;
  logic                           grant1;
  logic                           accept0;
  logic                           accept1;
  logic [ENTRY_W-1:0]             push_data;
  logic [ENTRY_W-1:0]             head;
  logic [FIFO_ADDR_WIDTH:0]       count;
  logic                           full;
  logic                           empty;
  logic                           head_ctx;
  logic [CONVEYOR_ADDR_WIDTH-1:0] head_slot;
  logic [FAULT_ADDR_WIDTH-1:0]    head_fault;
  logic [WORD_WIDTH-1:0]          head_value;

  // Ready is a function of the other port's valid only; a contested cycle
  // goes to whichever port did not win the previous accept.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!full) begin
      grant0 = !bus.p1_valid || last_grant_q;
      grant1 = !bus.p0_valid || !last_grant_q;
    end
  end

  assign accept0      = bus.p0_valid && grant0;
  assign accept1      = bus.p1_valid && grant1;
  assign bus.p0_ready = grant0;
  assign bus.p1_ready = grant1;

  assign push_data = accept1
    ? {bus.p1_ctx, bus.p1_slot, bus.p1_fault, bus.p1_value}
    : {bus.p0_ctx, bus.p0_slot, bus.p0_fault, bus.p0_value};

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept0)      last_grant_d = 1'b0;
    else if (accept1) last_grant_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= 1'b1;
    else          last_grant_q <= last_grant_d;
  end

  retire_fifo #(
    .ADDR_WIDTH (FIFO_ADDR_WIDTH),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (accept0 || accept1),
    .push_data_i (push_data),
    .pop_i       (bus.cv_ready),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign {head_ctx, head_slot, head_fault, head_value} = head;

  always_comb begin
    bus.cv_we    = !empty;
    bus.cv_ctx   = 1'b0;
    bus.cv_slot  = '0;
    bus.cv_entry = '0;
    if (!empty) begin
      bus.cv_ctx   = head_ctx;
      bus.cv_slot  = head_slot;
      bus.cv_entry = {1'b1, head_fault, head_value};
    end
  end

  assign bus.pending = count;
  assign bus.idle    = empty && !bus.p0_valid && !bus.p1_valid;

endmodule
`default_nettype wire

// File: tb/tb_conveyor_retire.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conveyor_retire -- vector table, directed corners, random vs model  |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_conveyor_retire;
  import conveyor_pkg::*;

  localparam int WW    = DEFAULT_WORD_WIDTH;
  localparam int SW    = DEFAULT_CONVEYOR_ADDR_WIDTH;
  localparam int FW    = DEFAULT_FAULT_ADDR_WIDTH;
  localparam int AW    = DEFAULT_FIFO_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  conveyor_retire_if #(.WORD_WIDTH(WW), .CONVEYOR_ADDR_WIDTH(SW),
                       .FAULT_ADDR_WIDTH(FW), .FIFO_ADDR_WIDTH(AW)) bus ();

  conveyor_retire #(.WORD_WIDTH(WW), .CONVEYOR_ADDR_WIDTH(SW),
                    .FAULT_ADDR_WIDTH(FW), .FIFO_ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  retire_entry_t mq[$];
  bit            m_last = 1'b1;
  bit            acc0 = 1'b0;
  bit            acc1 = 1'b0;

  logic                s_p0r, s_p1r, s_we, s_ctx, s_idle;
  logic [SW-1:0]       s_slot;
  logic [FW+WW:0]      s_entry;
  logic [AW:0]         s_pend;

  typedef struct {
    bit          p1v;
    bit          cvr;
    logic [SW-1:0] slot;
    bit          e_p1r;
    bit          e_we;
    logic [SW-1:0] e_slot;
    int          e_pend;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: sample at negedge, compare with the model, advance the model at posedge.
  task automatic cycle();
    bit full, e0, e1;
    retire_entry_t h;
    @(negedge clk);
    s_p0r = bus.p0_ready;  s_p1r = bus.p1_ready;  s_we = bus.cv_we;
    s_ctx = bus.cv_ctx;    s_slot = bus.cv_slot;  s_entry = bus.cv_entry;
    s_pend = bus.pending;  s_idle = bus.idle;
    full = (mq.size() == DEPTH);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!full) begin
      if (bus.p0_valid && bus.p1_valid) begin
        if (m_last) e0 = 1'b1;
        else        e1 = 1'b1;
      end else begin
        e0 = bus.p0_valid;
        e1 = bus.p1_valid;
      end
    end
    if (bus.p0_valid) chk("p0_ready", 64'(s_p0r), 64'(e0));
    if (bus.p1_valid) chk("p1_ready", 64'(s_p1r), 64'(e1));
    chk("cv_we", 64'(s_we), 64'(mq.size() != 0));
    chk("pending", 64'(s_pend), 64'(mq.size()));
    chk("idle", 64'(s_idle), 64'(mq.size() == 0 && !bus.p0_valid && !bus.p1_valid));
    if (mq.size() != 0) begin
      h = mq[0];
      chk("cv_ctx", 64'(s_ctx), 64'(h.ctx));
      chk("cv_slot", 64'(s_slot), 64'(h.slot));
      chk("cv_entry", 64'(s_entry), 64'({1'b1, h.fault, h.value}));
    end
    @(posedge clk);
    if (mq.size() != 0 && bus.cv_ready) void'(mq.pop_front());
    if (e0) begin
      mq.push_back('{bus.p0_ctx, bus.p0_slot, bus.p0_fault, bus.p0_value});
      m_last = 1'b0;
    end
    if (e1) begin
      mq.push_back('{bus.p1_ctx, bus.p1_slot, bus.p1_fault, bus.p1_value});
      m_last = 1'b1;
    end
    acc0 = e0;
    acc1 = e1;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.p0_valid = 1'b0;
    bus.p1_valid = 1'b0;
    bus.cv_ready = 1'b1;
    mq.delete();
    m_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [SW-1:0] s0, s1;

    bus.p0_valid = 1'b0; bus.p0_ctx = 1'b0; bus.p0_slot = '0; bus.p0_fault = '0; bus.p0_value = '0;
    bus.p1_valid = 1'b0; bus.p1_ctx = 1'b0; bus.p1_slot = '0; bus.p1_fault = '0; bus.p1_value = '0;
    bus.cv_ready = 1'b1;

    // Reset values
    do_reset();
    chk("rst_cv_we", 64'(bus.cv_we), 64'(0));
    chk("rst_pending", 64'(bus.pending), 64'(0));
    chk("rst_cv_ctx", 64'(bus.cv_ctx), 64'(0));
    chk("rst_cv_slot", 64'(bus.cv_slot), 64'(0));
    chk("rst_cv_entry", 64'(bus.cv_entry), 64'(0));
    chk("rst_idle", 64'(bus.idle), 64'(1));

    // Single p0 result, one-cycle latency
    bus.p0_valid = 1'b1; bus.p0_ctx = 1'b0; bus.p0_slot = 4'd3;
    bus.p0_fault = F_NONE; bus.p0_value = 32'hDEADBEEF;
    cycle();
    chk("t1_p0_ready", 64'(s_p0r), 64'(1));
    bus.p0_valid = 1'b0;
    cycle();
    chk("t1_cv_we", 64'(s_we), 64'(1));
    chk("t1_cv_slot", 64'(s_slot), 64'(3));
    chk("t1_cv_entry", 64'(s_entry), 64'({1'b1, F_NONE, 32'hDEADBEEF}));
    cycle();
    chk("t1_pending", 64'(s_pend), 64'(0));

    // Backpressure table: p1 only, conveyor stalled then released
    tbl[0]  = '{1, 0, 4'd1, 1, 0, 4'd0, 0};
    tbl[1]  = '{1, 0, 4'd2, 1, 1, 4'd1, 1};
    tbl[2]  = '{1, 0, 4'd3, 1, 1, 4'd1, 2};
    tbl[3]  = '{1, 0, 4'd4, 1, 1, 4'd1, 3};
    tbl[4]  = '{1, 0, 4'd5, 0, 1, 4'd1, 4};
    tbl[5]  = '{1, 1, 4'd5, 0, 1, 4'd1, 4};
    tbl[6]  = '{1, 1, 4'd5, 1, 1, 4'd2, 3};
    tbl[7]  = '{0, 1, 4'd0, 0, 1, 4'd3, 3};
    tbl[8]  = '{0, 1, 4'd0, 0, 1, 4'd4, 2};
    tbl[9]  = '{0, 1, 4'd0, 0, 1, 4'd5, 1};
    tbl[10] = '{0, 1, 4'd0, 0, 0, 4'd0, 0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      bus.p1_valid = tbl[i].p1v;
      bus.p1_ctx   = 1'b0;
      bus.p1_slot  = tbl[i].slot;
      bus.p1_fault = F_NONE;
      bus.p1_value = WW'(tbl[i].slot) * 32'h11111111;
      bus.cv_ready = tbl[i].cvr;
      cycle();
      if (tbl[i].p1v) chk("tbl_p1_ready", 64'(s_p1r), 64'(tbl[i].e_p1r));
      chk("tbl_cv_we", 64'(s_we), 64'(tbl[i].e_we));
      chk("tbl_pending", 64'(s_pend), 64'(tbl[i].e_pend));
      if (tbl[i].e_we) chk("tbl_cv_slot", 64'(s_slot), 64'(tbl[i].e_slot));
    end

    // Round-robin under continuous contention
    do_reset();
    s0 = 4'd0;
    s1 = 4'd1;
    for (int i = 0; i < 8; i++) begin
      bus.p0_valid = 1'b1; bus.p0_ctx = 1'b0; bus.p0_slot = s0; bus.p0_fault = F_NONE; bus.p0_value = WW'(s0);
      bus.p1_valid = 1'b1; bus.p1_ctx = 1'b1; bus.p1_slot = s1; bus.p1_fault = F_NONE; bus.p1_value = WW'(s1);
      cycle();
      chk("alt_grant", 64'({s_p0r, s_p1r}), 64'((i % 2 == 0) ? 2'b10 : 2'b01));
      if (acc0) s0 = s0 + 4'd2;
      if (acc1) s1 = s1 + 4'd2;
    end
    bus.p0_valid = 1'b0;
    bus.p1_valid = 1'b0;
    repeat (2) cycle();

    // Same {ctx, slot} twice: acceptance order, last write wins
    bus.p0_valid = 1'b1; bus.p0_ctx = 1'b1; bus.p0_slot = 4'd15; bus.p0_fault = F_NONE; bus.p0_value = 32'h1;
    cycle();
    bus.p0_value = 32'h2;
    cycle();
    chk("same_slot_first", 64'(s_entry[WW-1:0]), 64'(32'h1));
    bus.p0_valid = 1'b0;
    cycle();
    chk("same_slot_last", 64'(s_entry[WW-1:0]), 64'(32'h2));
    chk("same_slot_ctx", 64'(s_ctx), 64'(1));
    chk("same_slot_slot", 64'(s_slot), 64'(15));

    // Fault code passes through on the memory port
    bus.p1_valid = 1'b1; bus.p1_ctx = 1'b0; bus.p1_slot = 4'd7; bus.p1_fault = 3'b010; bus.p1_value = 32'hCAFE;
    cycle();
    bus.p1_valid = 1'b0;
    cycle();
    chk("fault_field", 64'(s_entry[FW+WW:WW]), 64'(4'b1010));

    // Asynchronous reset with three results buffered
    bus.cv_ready = 1'b0;
    bus.p0_valid = 1'b1; bus.p0_ctx = 1'b0; bus.p0_fault = F_NONE;
    for (int i = 0; i < 3; i++) begin
      bus.p0_slot = SW'(i + 8);
      bus.p0_value = WW'(i + 100);
      cycle();
    end
    bus.p0_valid = 1'b0;
    chk("pre_rst_pending", 64'(bus.pending), 64'(3));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_we", 64'(bus.cv_we), 64'(0));
    chk("async_rst_pending", 64'(bus.pending), 64'(0));
    mq.delete();
    m_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.cv_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.p0_valid = 1'b1; bus.p0_slot = 4'd1; bus.p0_value = 32'hA0;
    bus.p1_valid = 1'b1; bus.p1_ctx = 1'b0; bus.p1_slot = 4'd2; bus.p1_fault = F_NONE; bus.p1_value = 32'hB0;
    cycle();
    chk("post_rst_first_grant", 64'({s_p0r, s_p1r}), 64'(2'b10));
    bus.p0_valid = 1'b0;
    bus.p1_valid = 1'b0;
    repeat (3) cycle();

    // Randomized traffic with producers holding until accepted
    acc0 = 1'b0;
    acc1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!bus.p0_valid || acc0) begin
        bus.p0_valid = ($urandom % 3) != 0;
        bus.p0_ctx   = 1'($urandom);
        bus.p0_slot  = SW'($urandom);
        bus.p0_fault = FW'($urandom);
        bus.p0_value = $urandom;
      end
      if (!bus.p1_valid || acc1) begin
        bus.p1_valid = ($urandom % 3) != 0;
        bus.p1_ctx   = 1'($urandom);
        bus.p1_slot  = SW'($urandom);
        bus.p1_fault = FW'($urandom);
        bus.p1_value = $urandom;
      end
      bus.cv_ready = ((i % 200) < 30) ? (($urandom % 8) == 0) : (($urandom % 4) != 0);
      cycle();
    end
    bus.p0_valid = 1'b0;
    bus.p1_valid = 1'b0;
    bus.cv_ready = 1'b1;
    repeat (6) cycle();
    chk("drain_idle", 64'(s_idle), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conveyor_retire.md
Name: conveyor_retire

Overview:
- Write-side companion to the conveyor controller. Collects completed asynchronous results from two producer ports (port 0 = ALU/multi-cycle pipeline, port 1 = memory unit). Each result carries a target conveyor slot, context bit and fault code.
- Arbitrates between the producers, buffers results in a small FIFO and retires one slot write per cycle into the conveyor storage, marked finished.
- Once retired, a slot releases any CVZ halt waiting on it.

Parameters:
- WORD_WIDTH, 32, data word width
- CONVEYOR_ADDR_WIDTH, 4, conveyor slot index width
- FAULT_ADDR_WIDTH, 3, fault code width (matches shared fault encoding)
- FIFO_ADDR_WIDTH, 2, log2 of retire FIFO depth (default depth 4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- p0_valid  in  1  pipeline result valid
- p0_ready  out  1  pipeline result accepted this cycle when high with p0_valid
- p0_ctx  in  1  context: 0 = main, 1 = interrupt conveyor
- p0_slot  in  CONVEYOR_ADDR_WIDTH  target slot
- p0_fault  in  FAULT_ADDR_WIDTH  fault code; F_NONE if clean
- p0_value  in  WORD_WIDTH  result word
- p1_valid / p1_ready / p1_ctx / p1_slot / p1_fault / p1_value  same widths and meanings, memory port
- cv_we  out  1  conveyor write strobe
- cv_ready  in  1  conveyor can accept the write; low during load_last or interrupt-entry writes
- cv_ctx  out  1  conveyor select
- cv_slot  out  CONVEYOR_ADDR_WIDTH  slot written
- cv_entry  out  1+FAULT_ADDR_WIDTH+WORD_WIDTH  {finished=1, fault, value}
- pending  out  FIFO_ADDR_WIDTH+1  FIFO occupancy
- idle  out  1  FIFO empty and no producer valid

Behaviour:
- Reset (reset_n low, asynchronous): FIFO pointers and count = 0; last_grant = 1 so port 0 wins first; cv_we = 0; cv_ctx, cv_slot and cv_entry = 0; pending = 0.
  - Reset mid-operation discards all buffered results without performing a write.
- Accept:
  - At most one producer accepted per cycle.
  - full = (pending == depth). While full, p0_ready = p1_ready = 0 regardless of pops in that cycle; there is no push-on-full bypass.
  - Not full, single valid: that port's ready = 1.
  - Not full, both valid: round-robin. The grant goes to the port not granted last; last_grant updates only on an actual accept.
  - ready never depends on the port's own valid. It may depend on the other port's valid.
  - Producers hold valid/payload stable until accepted.
- Push: the accepted {ctx, slot, fault, value} is written to FIFO tail at the clock edge.
- Retire:
  - cv_we = !empty, driven combinationally from the FIFO head.
  - cv_entry = {1'b1, head.fault, head.value}; cv_ctx and cv_slot come from head.
  - The head pops at an edge where cv_we && cv_ready.
  - While cv_ready is low, the head is held and outputs stay stable.
- Latency: result accepted at edge N appears on cv_* in cycle N+1 (minimum 1 cycle). Throughput is 1 retire per cycle.
- Simultaneous push and pop when not full: pending is unchanged and ordering is preserved.
- Ordering: strict FIFO across both ports. Two results to the same {ctx, slot} retire in acceptance order, so the last accepted wins.
- Faults: the fault code passes through unchanged. This block never generates faults.
- Slot and pointer arithmetic is modulo 2^width, with wrap-around natural.
- idle = (pending == 0) && !p0_valid && !p1_valid.

Decomposition:
- Shared package conveyor_pkg:
  - CONVEYOR_WIDTH
  - fault codes (F_NONE etc., reused from the fault definitions)
  - typedef retire_entry_t {ctx, slot, fault, value}
  - typedef conveyor_slot_t {finished, fault, value}
- One sub-module: retire_fifo (parameterised depth/width, synchronous push/pop, count, full/empty, async active-low reset).
- Arbitration and output mapping live in the top.

Test Plan:
- Reset then p0 {ctx0, slot 3, F_NONE, 0xDEADBEEF}, cv_ready=1 -> p0_ready=1; next cycle cv_we=1, cv_slot=3, cv_entry={1,F_NONE,0xDEADBEEF}; pending returns to 0.
- p0 and p1 valid continuously, cv_ready=1 -> grants alternate p0,p1,p0,p1; cv_slot sequence matches acceptance order.
- cv_ready=0 with 5 pushes on p1 -> first 4 accepted, pending=4, p1_ready=0 on 5th. Raise cv_ready -> 4 writes in order; 5th accepted on the cycle after the first pop.
- Two results to {ctx1, slot 15}, values 0x1 then 0x2 -> retire in that order, final write value 0x2, cv_ctx=1.
- p1 fault code 3'b010 -> cv_entry fault field = 3'b010, finished=1.
- Assert reset_n low with pending=3 between edges -> cv_we=0 immediately, pending=0. After release, first grant goes to p0.
